// File: rtl/rom_access_arbiter_if.sv
// Bus bundle between the CPU pipeline (IF and MEM requesters), the ROM
// access arbiter and the combinational program ROM.
//   slave  : arbiter side
//   master : pipeline + ROM side (drives requests and ROM return data)
interface rom_access_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic        if_fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic        mem_fault;
    logic [31:0] rdata;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_accessable;

    modport slave (
        input  if_req, if_addr, mem_req, mem_addr, rom_data, rom_accessable,
        output if_gnt, if_rvalid, if_fault, mem_gnt, mem_rvalid, mem_fault,
               rdata, rom_addr
    );

    modport master (
        output if_req, if_addr, mem_req, mem_addr, rom_data, rom_accessable,
        input  if_gnt, if_rvalid, if_fault, mem_gnt, mem_rvalid, mem_fault,
               rdata, rom_addr
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one combinational program ROM between the
// instruction-fetch (IF) and MEM requesters. Each access runs
// IDLE -> ACCESS (WAIT_STATES extra cycles) -> RESP -> IDLE.
// MEM wins conflicts unless IF has lost STARVE_LIMIT conflicts in a row.
// Optional feature macro: ROM_ARB_STATS_EN adds saturating 16-bit grant and
// conflict counters as extra output ports.
module rom_access_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int WAIT_STATES  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    rom_access_arbiter_if.slave  bus
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]          stat_if_grants,
    output logic [15:0]          stat_mem_grants,
    output logic [15:0]          stat_conflicts
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [2:0] WAITS = 3'(WAIT_STATES);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        if_win, mem_win, conflict;

    // Arbitration in IDLE, wait-state sequencing in ACCESS, data capture at end of ACCESS
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wcnt_d     = wcnt_q;
        starve_d   = starve_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        if_win     = 1'b0;
        mem_win    = 1'b0;
        conflict   = 1'b0;
        case (state_q)
            IDLE: begin
                conflict = bus.if_req && bus.mem_req;
                if (bus.if_req && (!bus.mem_req || starve_q == LIMIT)) begin
                    if_win = 1'b1;
                end else if (bus.mem_req) begin
                    mem_win = 1'b1;
                end
                if (if_win) begin
                    owner_d    = OWN_IF;
                    rom_addr_d = bus.if_addr;
                    starve_d   = 4'd0;
                end else if (mem_win) begin
                    owner_d    = OWN_MEM;
                    rom_addr_d = bus.mem_addr;
                    // IF just lost a conflict; the count saturates at the limit
                    if (conflict && starve_q != LIMIT) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
                if (if_win || mem_win) begin
                    wcnt_d  = WAITS;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else begin
                    rdata_d = bus.rom_accessable ? bus.rom_data : 32'd0;
                    fault_d = ~bus.rom_accessable;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            wcnt_q     <= 3'd0;
            starve_q   <= 4'd0;
            rom_addr_q <= 32'd0;
            rdata_q    <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wcnt_q     <= wcnt_d;
            starve_q   <= starve_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
        end
    end

    // Grants are combinational in IDLE; responses go to the owner during RESP
    always_comb begin
        bus.if_gnt     = if_win  && !reset;
        bus.mem_gnt    = mem_win && !reset;
        bus.if_rvalid  = (state_q == RESP) && (owner_q == OWN_IF)  && !reset;
        bus.mem_rvalid = (state_q == RESP) && (owner_q == OWN_MEM) && !reset;
        bus.if_fault   = bus.if_rvalid  && fault_q;
        bus.mem_fault  = bus.mem_rvalid && fault_q;
        bus.rdata      = rdata_q;
        bus.rom_addr   = rom_addr_q;
    end

`ifdef ROM_ARB_STATS_EN
    logic [15:0] stat_if_q, stat_if_d;
    logic [15:0] stat_mem_q, stat_mem_d;
    logic [15:0] stat_cf_q, stat_cf_d;

    // Saturating usage counters
    always_comb begin
        stat_if_d  = stat_if_q;
        stat_mem_d = stat_mem_q;
        stat_cf_d  = stat_cf_q;
        if (if_win && stat_if_q != 16'hFFFF)    stat_if_d  = stat_if_q + 16'd1;
        if (mem_win && stat_mem_q != 16'hFFFF)  stat_mem_d = stat_mem_q + 16'd1;
        if (conflict && stat_cf_q != 16'hFFFF)  stat_cf_d  = stat_cf_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_if_q  <= 16'd0;
            stat_mem_q <= 16'd0;
            stat_cf_q  <= 16'd0;
        end else begin
            stat_if_q  <= stat_if_d;
            stat_mem_q <= stat_mem_d;
            stat_cf_q  <= stat_cf_d;
        end
    end

    assign stat_if_grants  = stat_if_q;
    assign stat_mem_grants = stat_mem_q;
    assign stat_conflicts  = stat_cf_q;
`endif

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Testbench for rom_access_arbiter: a zero-wait-state instance exercised by a
// transaction table plus starvation and reset-in-flight sequences, and a
// three-wait-state instance for the latency sequence.
module tb_rom_access_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rom_access_arbiter_if bus0();
    rom_access_arbiter_if bus3();

`ifdef ROM_ARB_STATS_EN
    logic [15:0] s0_if, s0_mem, s0_cf, s3_if, s3_mem, s3_cf;
`endif

    rom_access_arbiter #(.STARVE_LIMIT(4), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0)
`ifdef ROM_ARB_STATS_EN
        , .stat_if_grants(s0_if), .stat_mem_grants(s0_mem), .stat_conflicts(s0_cf)
`endif
    );

    rom_access_arbiter #(.STARVE_LIMIT(4), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst), .bus(bus3)
`ifdef ROM_ARB_STATS_EN
        , .stat_if_grants(s3_if), .stat_mem_grants(s3_mem), .stat_conflicts(s3_cf)
`endif
    );

    // ROM image aliased at 0x0000_0000 and 0x0040_0000 (4 KiB); word-aligned only
    function automatic logic rom_hit(input logic [31:0] a);
        return (a[31:12] == 20'h00000 || a[31:12] == 20'h00400) && a[1:0] == 2'b00;
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [9:0] idx;
        idx = a[11:2];
        if (!(a[31:12] == 20'h00000 || a[31:12] == 20'h00400)) return 32'hDEAD_BEEF;
        case (idx)
            10'd0:   return 32'h3C1D_0001;
            10'd1:   return 32'h0810_0055;
            10'd2:   return 32'h2402_000A;
            default: return {22'd0, idx} ^ 32'hA5A5_0000;
        endcase
    endfunction

    always_comb begin
        bus0.rom_accessable = rom_hit(bus0.rom_addr);
        bus0.rom_data       = rom_word(bus0.rom_addr);
        bus3.rom_accessable = rom_hit(bus3.rom_addr);
        bus3.rom_data       = rom_word(bus3.rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        mr;
        logic [31:0] ma;
        logic        win_mem;
        logic [31:0] exp_addr;
        logic        exp_fault;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    // One full zero-wait transaction on bus0: gnt at T, rom_addr at T+1, response at T+2
    task automatic run_vec(input vec_t v, input int i);
        bus0.if_req   = v.ir;
        bus0.if_addr  = v.ia;
        bus0.mem_req  = v.mr;
        bus0.mem_addr = v.ma;
        @(negedge clk);
        chk($sformatf("v%0d_if_gnt", i), bus0.if_gnt, !v.win_mem);
        chk($sformatf("v%0d_mem_gnt", i), bus0.mem_gnt, v.win_mem);
        next_cycle();
        bus0.if_req   = 1'b0;
        bus0.mem_req  = 1'b0;
        bus0.if_addr  = 32'hFFFF_FFF0;
        bus0.mem_addr = 32'hFFFF_FFF0;
        @(negedge clk);
        chk($sformatf("v%0d_rom_addr", i), bus0.rom_addr, v.exp_addr);
        chk($sformatf("v%0d_no_gnt_access", i), {bus0.if_gnt, bus0.mem_gnt}, 0);
        next_cycle();
        @(negedge clk);
        chk($sformatf("v%0d_if_rvalid", i), bus0.if_rvalid, !v.win_mem);
        chk($sformatf("v%0d_mem_rvalid", i), bus0.mem_rvalid, v.win_mem);
        chk($sformatf("v%0d_if_fault", i), bus0.if_fault, !v.win_mem && v.exp_fault);
        chk($sformatf("v%0d_mem_fault", i), bus0.mem_fault, v.win_mem && v.exp_fault);
        chk($sformatf("v%0d_rdata", i), bus0.rdata, v.exp_rdata);
        next_cycle();
        @(negedge clk);
        chk($sformatf("v%0d_rvalid_idle", i), {bus0.if_rvalid, bus0.mem_rvalid}, 0);
        chk($sformatf("v%0d_rdata_hold", i), bus0.rdata, v.exp_rdata);
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] exp_mem;
        logic       found;
        int         waited;
`ifdef ROM_ARB_STATS_EN
        logic [15:0] b_if, b_mem, b_cf;
`endif
        vecs[0] = '{1'b1, 32'h0040_0000, 1'b0, 32'h0,         1'b0, 32'h0040_0000, 1'b0, 32'h3C1D_0001};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 1'b0, 32'h0810_0055};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_0002, 1'b1, 32'h0000_0002, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 32'h1000_0000, 1'b1, 32'h1000_0000, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h0040_0001, 1'b0, 32'h0,         1'b0, 32'h0040_0001, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h0040_0008, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, 1'b0, 32'h2402_000A};
        vecs[6] = '{1'b1, 32'h0040_0004, 1'b0, 32'h0,         1'b0, 32'h0040_0004, 1'b0, 32'h0810_0055};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h3C1D_0001};

        // Reset with both requests high: nothing may be granted
        rst = 1'b1;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h0040_0000;
        bus0.mem_req = 1'b1; bus0.mem_addr = 32'h0000_0004;
        bus3.if_req = 1'b0; bus3.if_addr = 32'h0;
        bus3.mem_req = 1'b0; bus3.mem_addr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {bus0.if_gnt, bus0.mem_gnt}, 0);
        chk("rst_rvalid", {bus0.if_rvalid, bus0.mem_rvalid}, 0);
        chk("rst_fault", {bus0.if_fault, bus0.mem_fault}, 0);
        chk("rst_rom_addr", bus0.rom_addr, 32'h0);
        chk("rst_rdata", bus0.rdata, 32'h0);
        chk("rst_starve", dut0.starve_q, 0);
        next_cycle();
        rst = 1'b0;
        bus0.if_req = 1'b0;
        bus0.mem_req = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Both requesters held: MEM x4, IF, MEM x4, IF
`ifdef ROM_ARB_STATS_EN
        b_if = s0_if; b_mem = s0_mem; b_cf = s0_cf;
`endif
        exp_mem = 10'b01111_01111;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h0040_0000;
        bus0.mem_req = 1'b1; bus0.mem_addr = 32'h0000_0004;
        for (int g = 0; g < 10; g++) begin
            found = 1'b0;
            waited = 0;
            while (!found && waited < 8) begin
                @(negedge clk);
                if (bus0.if_gnt || bus0.mem_gnt) found = 1'b1;
                else waited++;
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL starve_g%0d_timeout: got no grant expected grant", g);
            end else begin
                chk($sformatf("starve_g%0d_one_hot", g), bus0.if_gnt && bus0.mem_gnt, 0);
                chk($sformatf("starve_g%0d_mem_wins", g), bus0.mem_gnt, exp_mem[g]);
                if (!exp_mem[g]) begin
                    chk($sformatf("starve_g%0d_cnt_at_limit", g), dut0.starve_q, 4);
                    @(negedge clk);
                    chk($sformatf("starve_g%0d_cnt_cleared", g), dut0.starve_q, 0);
                end
            end
        end
        bus0.if_req = 1'b0;
        bus0.mem_req = 1'b0;
        repeat (3) next_cycle();
`ifdef ROM_ARB_STATS_EN
        chk("stat_mem_grants", s0_mem - b_mem, 16'd8);
        chk("stat_if_grants", s0_if - b_if, 16'd2);
        chk("stat_conflicts", s0_cf - b_cf, 16'd10);
`endif

        // Three wait states: if_rvalid exactly 5 cycles after if_gnt, MEM locked out meanwhile
        bus3.if_req = 1'b1; bus3.if_addr = 32'h0040_0008;
        @(negedge clk);
        chk("ws3_if_gnt", bus3.if_gnt, 1);
        next_cycle();
        bus3.if_req = 1'b0;
        bus3.mem_req = 1'b1; bus3.mem_addr = 32'h0000_0004;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("ws3_c%0d_mem_gnt", c), bus3.mem_gnt, 0);
            chk($sformatf("ws3_c%0d_if_rvalid", c), bus3.if_rvalid, c == 5);
            if (c == 5) begin
                chk("ws3_rdata", bus3.rdata, 32'h2402_000A);
                chk("ws3_if_fault", bus3.if_fault, 0);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("ws3_mem_gnt_after", bus3.mem_gnt, 1);
        next_cycle();
        bus3.mem_req = 1'b0;
        repeat (6) next_cycle();

        // Reset during ACCESS drops the transaction; new request granted right after
        bus0.if_req = 1'b1; bus0.if_addr = 32'h0040_0004;
        @(negedge clk);
        chk("rip_if_gnt", bus0.if_gnt, 1);
        next_cycle();
        bus0.if_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rip_rvalid_in_reset", bus0.if_rvalid, 0);
        next_cycle();
        rst = 1'b0;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h0040_0000;
        @(negedge clk);
        chk("rip_no_rvalid", {bus0.if_rvalid, bus0.mem_rvalid}, 0);
        chk("rip_new_gnt", bus0.if_gnt, 1);
        chk("rip_rdata_cleared", bus0.rdata, 32'h0);
        next_cycle();
        bus0.if_req = 1'b0;
        @(negedge clk);
        chk("rip_access_no_rvalid", bus0.if_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("rip_new_rvalid", bus0.if_rvalid, 1);
        chk("rip_new_rdata", bus0.rdata, 32'h3C1D_0001);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
